// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared constants and types for the RV32 M-extension unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Base ISA opcode defines used by the decoder alongside this unit
    localparam logic [6:0] c_OPCODE_OP    = 7'b0110011;
    localparam logic [6:0] c_FUNCT7_MULDIV = 7'b0000001;

    localparam int c_XLEN = 32;
    localparam int c_ITER = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } func3_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative radix-2 multiply/divide unit for RV32 M-extension.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        func3,
    input  logic [c_XLEN-1:0] rs1,
    input  logic [c_XLEN-1:0] rs2,
    input  logic              flush,
    output logic              stall,
    output logic              done,
    output logic [c_XLEN-1:0] result
);

    state_e              r_state;
    state_e              w_next_state;
    func3_e              r_f3;
    logic [5:0]          r_cnt;
    logic [63:0]         r_acc;
    logic [c_XLEN-1:0]   r_opb;
    logic                r_neg_a;
    logic                r_neg_b;
    logic [c_XLEN-1:0]   r_result;

    logic                w_is_div;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [c_XLEN-1:0]   w_mag_a;
    logic [c_XLEN-1:0]   w_mag_b;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic                w_special;
    logic [c_XLEN-1:0]   w_special_result;
    logic [32:0]         w_mul_sum;
    logic [32:0]         w_rem_sh;
    logic [32:0]         w_div_diff;
    logic [63:0]         w_step;
    logic [63:0]         w_prod;
    logic [c_XLEN-1:0]   w_quot;
    logic [c_XLEN-1:0]   w_rem;
    logic [c_XLEN-1:0]   w_fixed;

    // Operand decode: func3[2] selects divide; bit 0 marks the unsigned divide forms
    assign w_is_div   = func3[2];
    assign w_a_signed = w_is_div ? ~func3[0] : (func3[1:0] != 2'b11);
    assign w_b_signed = w_is_div ? ~func3[0] : (func3[1] == 1'b0);
    assign w_a_neg    = w_a_signed & rs1[c_XLEN-1];
    assign w_b_neg    = w_b_signed & rs2[c_XLEN-1];
    assign w_mag_a    = w_a_neg ? (~rs1 + 32'd1) : rs1;
    assign w_mag_b    = w_b_neg ? (~rs2 + 32'd1) : rs2;

    assign w_div_zero = w_is_div && (rs2 == 32'd0);
    assign w_div_ovf  = w_is_div && !func3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
    assign w_special  = w_div_zero || w_div_ovf;

    always_comb begin
        w_special_result = 32'd0;
        if (w_div_zero)
            w_special_result = func3[1] ? rs1 : 32'hFFFF_FFFF;
        else if (w_div_ovf)
            w_special_result = func3[1] ? 32'd0 : 32'h8000_0000;
    end

    // Multiply: conditional add of the multiplicand into the upper half, shift right.
    // Divide: restoring step on the {remainder, dividend/quotient} pair, shift left.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
    assign w_rem_sh   = r_acc[63:31];
    assign w_div_diff = w_rem_sh - {1'b0, r_opb};
    assign w_step     = !r_f3[2] ? {w_mul_sum, r_acc[31:1]}
                      : w_div_diff[32] ? {w_rem_sh[31:0], r_acc[30:0], 1'b0}
                      : {w_div_diff[31:0], r_acc[30:0], 1'b1};

    assign w_prod = (r_neg_a ^ r_neg_b) ? (~r_acc + 64'd1) : r_acc;
    assign w_quot = (r_neg_a ^ r_neg_b) ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_rem  = r_neg_a ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

    always_comb begin
        w_fixed = w_prod[31:0];
        case (r_f3)
            F3_MUL:                       w_fixed = w_prod[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_fixed = w_prod[63:32];
            F3_DIV, F3_DIVU:              w_fixed = w_quot;
            default:                      w_fixed = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = w_special ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == 6'(c_ITER - 1)) w_next_state = S_FIXUP;
            S_FIXUP: w_next_state = S_DONE;
            default: w_next_state = S_IDLE;
        endcase
        if (flush)
            w_next_state = S_IDLE;
    end

    assign stall  = ((r_state == S_IDLE) && start) || (r_state == S_CALC) || (r_state == S_FIXUP);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_f3     <= F3_MUL;
            r_cnt    <= 6'd0;
            r_acc    <= 64'd0;
            r_opb    <= 32'd0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_result <= 32'd0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_f3    <= func3_e'(func3);
                        r_cnt   <= 6'd0;
                        r_neg_a <= w_a_neg;
                        r_neg_b <= w_b_neg;
                        r_acc   <= {32'd0, w_mag_a};
                        r_opb   <= w_mag_b;
                        if (w_special)
                            r_result <= w_special_result;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 6'd1;
                    r_acc <= w_step;
                end
                S_FIXUP: r_result <= w_fixed;
                default: ;
            endcase
        end
    end

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] c_MUL = 3'b000, c_MULH = 3'b001, c_MULHSU = 3'b010, c_MULHU = 3'b011;
    localparam logic [2:0] c_DIV = 3'b100, c_DIVU = 3'b101, c_REM = 3'b110, c_REMU = 3'b111;

    muldiv_unit u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .func3  (func3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation; lat counts edges after the accept edge until done is seen
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output int stall_bad,
                         output logic done_after);
        stall_bad = 0;
        @(negedge clk);
        func3 = f; rs1 = a; rs2 = b; start = 1'b1;
        #1;
        if (stall !== 1'b1) stall_bad++;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (stall !== 1'b1) stall_bad++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        res = result;
        if (stall !== 1'b0) stall_bad++;
        @(posedge clk);
        @(negedge clk);
        done_after = done;
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; func3 = 3'b0; rs1 = 32'd0; rs2 = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (result !== 32'd0 || done !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset: result=%h done=%b stall=%b, want 00000000 0 0", result, done, stall);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        int lat, sb; logic [31:0] res; logic da;
        issue(c_MUL, 32'd7, 32'hFFFF_FFFD, lat, res, sb, da);
        checks++;
        if (res !== 32'hFFFF_FFEB || lat !== 33 || sb !== 0 || da !== 1'b0) begin
            errors++;
            $display("FAIL mul_7x-3: res=%h lat=%0d stall_bad=%0d done_after=%b, want ffffffeb 33 0 0", res, lat, sb, da);
        end
        issue(c_MUL, 32'h1234_5678, 32'h10, lat, res, sb, da);
        checks++;
        if (res !== 32'h2345_6780 || lat !== 33) begin
            errors++;
            $display("FAIL mul_shift: res=%h lat=%0d, want 23456780 33", res, lat);
        end
    endtask

    task automatic test_mulh();
        int lat, sb; logic [31:0] res; logic da;
        issue(c_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, sb, da);
        checks++;
        if (res !== 32'hFFFF_FFFE || lat !== 33) begin
            errors++;
            $display("FAIL mulhu_ones: res=%h lat=%0d, want fffffffe 33", res, lat);
        end
        issue(c_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, sb, da);
        checks++;
        if (res !== 32'h0000_0000) begin
            errors++;
            $display("FAIL mulh_ones: res=%h, want 00000000", res);
        end
        issue(c_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, sb, da);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mulhsu_ones: res=%h, want ffffffff", res);
        end
        issue(c_MULH, 32'h8000_0000, 32'h8000_0000, lat, res, sb, da);
        checks++;
        if (res !== 32'h4000_0000) begin
            errors++;
            $display("FAIL mulh_min: res=%h, want 40000000", res);
        end
    endtask

    task automatic test_div();
        int lat, sb; logic [31:0] res; logic da;
        issue(c_DIV, 32'hFFFF_FFF9, 32'd2, lat, res, sb, da);
        checks++;
        if (res !== 32'hFFFF_FFFD || lat !== 33 || sb !== 0) begin
            errors++;
            $display("FAIL div_-7/2: res=%h lat=%0d stall_bad=%0d, want fffffffd 33 0", res, lat, sb);
        end
        issue(c_REM, 32'hFFFF_FFF9, 32'd2, lat, res, sb, da);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL rem_-7%%2: res=%h, want ffffffff", res);
        end
        issue(c_DIVU, 32'd100, 32'd7, lat, res, sb, da);
        checks++;
        if (res !== 32'd14) begin
            errors++;
            $display("FAIL divu_100/7: res=%h, want 0000000e", res);
        end
        issue(c_REMU, 32'd100, 32'd7, lat, res, sb, da);
        checks++;
        if (res !== 32'd2) begin
            errors++;
            $display("FAIL remu_100%%7: res=%h, want 00000002", res);
        end
        issue(c_DIV, 32'd7, 32'hFFFF_FFFE, lat, res, sb, da);
        checks++;
        if (res !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_7/-2: res=%h, want fffffffd", res);
        end
        issue(c_REM, 32'd7, 32'hFFFF_FFFE, lat, res, sb, da);
        checks++;
        if (res !== 32'd1) begin
            errors++;
            $display("FAIL rem_7%%-2: res=%h, want 00000001", res);
        end
    endtask

    task automatic test_special();
        int lat, sb; logic [31:0] res; logic da;
        issue(c_DIVU, 32'd5, 32'd0, lat, res, sb, da);
        checks++;
        if (res !== 32'hFFFF_FFFF || lat !== 0 || sb !== 0 || da !== 1'b0) begin
            errors++;
            $display("FAIL divu_by0: res=%h lat=%0d stall_bad=%0d done_after=%b, want ffffffff 0 0 0", res, lat, sb, da);
        end
        issue(c_REM, 32'd5, 32'd0, lat, res, sb, da);
        checks++;
        if (res !== 32'd5 || lat !== 0) begin
            errors++;
            $display("FAIL rem_by0: res=%h lat=%0d, want 00000005 0", res, lat);
        end
        issue(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, sb, da);
        checks++;
        if (res !== 32'h8000_0000 || lat !== 0) begin
            errors++;
            $display("FAIL div_ovf: res=%h lat=%0d, want 80000000 0", res, lat);
        end
        issue(c_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, sb, da);
        checks++;
        if (res !== 32'd0 || lat !== 0) begin
            errors++;
            $display("FAIL rem_ovf: res=%h lat=%0d, want 00000000 0", res, lat);
        end
    endtask

    task automatic test_flush();
        int lat, sb, n; logic [31:0] res; logic da;
        issue(c_MUL, 32'd7, 32'hFFFF_FFFD, lat, res, sb, da);
        @(negedge clk);
        func3 = c_MULHU; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL flush_calc: stall=%b done=%b result=%h, want 0 0 ffffffeb", stall, done, result);
        end
        count_dones(40, n);
        checks++;
        if (n !== 0 || result !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL flush_quiet: dones=%0d result=%h, want 0 ffffffeb", n, result);
        end
        @(negedge clk);
        func3 = c_DIVU; rs1 = 32'd9; rs2 = 32'd0; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        count_dones(40, n);
        checks++;
        if (n !== 0 || result !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL flush_start_idle: dones=%0d result=%h, want 0 ffffffeb", n, result);
        end
        issue(c_DIVU, 32'd100, 32'd7, lat, res, sb, da);
        checks++;
        if (res !== 32'd14 || lat !== 33) begin
            errors++;
            $display("FAIL after_flush: res=%h lat=%0d, want 0000000e 33", res, lat);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        func3 = c_DIV; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (32) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (stall !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL fixup_reached: stall=%b done=%b, want 1 0", stall, done);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (result !== 32'd0 || done !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: result=%h done=%b stall=%b, want 00000000 0 0", result, done, stall);
        end
        rst_n = 1'b1;
        count_dones(40, n);
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: dones=%0d, want 0", n);
        end
    endtask

    task automatic test_start_held();
        int lat, n;
        @(negedge clk);
        func3 = c_MUL; rs1 = 32'd6; rs2 = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checks++;
        if (result !== 32'd42 || lat !== 33 || stall !== 1'b0) begin
            errors++;
            $display("FAIL start_held: res=%h lat=%0d stall=%b, want 0000002a 33 0", result, lat, stall);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        count_dones(40, n);
        checks++;
        if (n !== 0 || stall !== 1'b0 || result !== 32'd42) begin
            errors++;
            $display("FAIL no_reaccept: dones=%0d stall=%b result=%h, want 0 0 0000002a", n, stall, result);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_flush();
        test_reset_mid();
        test_start_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_muldiv_unit
`default_nettype wire
